int_ctrl_nested: RTL and testbench

Parametrised successor to the single-source EXE-stage interrupt logic. It arbitrates one NMI and NUM_IRQ maskable sources, and owns IFF1, IFF2, the interrupt mode and the EI shadow. It provides fully nested in-service tracking and raises a request to the flush unit at instruction boundaries. It sits beside the flush unit in the EXE stage and supplies the target PC and the IFF state to the result mux.

---
 rtl/int_ctrl_pkg.sv | 16 +
 rtl/int_prio_enc.sv | 22 ++
 rtl/int_ctrl_nested.sv | 150 +++++++++++++++
 tb/tb_int_ctrl_nested.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared encodings, vector addresses and sizing helpers for the nested interrupt controller.
package int_ctrl_pkg;

  localparam logic [1:0] IM0 = 2'd0;
  localparam logic [1:0] IM1 = 2'd1;
  localparam logic [1:0] IM2 = 2'd2;

  localparam logic [15:0] NMI_VEC = 16'h0066;
  localparam logic [15:0] IM1_VEC = 16'h0038;

  // Index width for n channels; never below one bit so ports stay legal for n=1.
  function automatic int unsigned chan_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder returning a valid flag and the winning index.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = chan_width(N)
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl_nested.sv
// EXE-stage interrupt controller: NMI plus NUM_IRQ nested maskable channels, IFF/IM/EI-shadow state.
// Optional macro INT_EDGE_EN makes the maskable channels edge-triggered with pending latches.
module int_ctrl_nested
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 4,
  parameter int unsigned EI_DELAY = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               nmi_in,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic               retn,
  input  logic               im_set,
  input  logic [1:0]         im_val,
  input  logic [7:0]         i_reg,
  input  logic               retire,
  input  logic               stall,
  input  logic               int_ack,
  output logic               interrupt_RQ,
  output logic [15:0]        target_pc,
  output logic               is_nmi,
  output logic               IFF1,
  output logic               IFF2,
  output logic [1:0]         int_mode,
  output logic [NUM_IRQ-1:0] in_service
);

  localparam int unsigned CW = chan_width(NUM_IRQ);

  logic               nmi_d;
  logic               nmi_pend;
  logic               nmi_edge;
  logic [1:0]         shadow;
  logic [NUM_IRQ-1:0] src;
  logic [NUM_IRQ-1:0] blocked;
  logic [NUM_IRQ-1:0] elig;
  logic               irq_valid;
  logic [CW-1:0]      irq_chan;
  logic               isv_valid;
  logic [CW-1:0]      isv_chan;
  logic               live;
  logic               accept;
  logic               take_nmi;
  logic               take_irq;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;

`ifdef INT_EDGE_EN
  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] irq_pend;

  // Edges latch regardless of mask; only the accepted channel is cleared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_d    <= '0;
      irq_pend <= '0;
    end else begin
      irq_d    <= irq_in;
      irq_pend <= (irq_pend & ~set_vec) | (irq_in & ~irq_d);
    end
  end

  assign src = irq_pend;
`else
  assign src = irq_in;
`endif

  // A channel is blocked by any in-service bit at its own or a higher-priority index.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    blocked = '0;
    for (int c = 0; c < int'(NUM_IRQ); c++) begin
      acc        = acc | in_service[c];
      blocked[c] = acc;
    end
  end

  assign elig = src & ~irq_mask & ~blocked;

  int_prio_enc #(.N(NUM_IRQ)) u_elig_enc (
    .req   (elig),
    .valid (irq_valid),
    .idx   (irq_chan)
  );

  int_prio_enc #(.N(NUM_IRQ)) u_isv_enc (
    .req   (in_service),
    .valid (isv_valid),
    .idx   (isv_chan)
  );

  assign nmi_edge     = nmi_in & ~nmi_d;
  assign is_nmi       = nmi_pend;
  assign interrupt_RQ = nmi_pend | (IFF1 & (shadow == 2'd0) & irq_valid);

  always_comb begin
    if (nmi_pend)             target_pc = NMI_VEC;
    else if (int_mode == IM2) target_pc = {i_reg, 4'b0000, 3'(irq_chan), 1'b0};
    else                      target_pc = IM1_VEC;
  end

  assign live     = ~stall;
  assign accept   = live & int_ack & interrupt_RQ;
  assign take_nmi = accept & nmi_pend;
  assign take_irq = accept & ~nmi_pend;
  assign set_vec  = take_irq ? (NUM_IRQ'(1) << irq_chan) : '0;
  assign clr_vec  = (live & reti & isv_valid) ? (NUM_IRQ'(1) << isv_chan) : '0;

  // Architectural state freezes under stall; NMI edge capture keeps running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      nmi_d      <= 1'b0;
      nmi_pend   <= 1'b0;
      shadow     <= 2'd0;
      IFF1       <= 1'b0;
      IFF2       <= 1'b0;
      int_mode   <= IM0;
      in_service <= '0;
    end else begin
      nmi_d    <= nmi_in;
      nmi_pend <= nmi_edge | (nmi_pend & ~take_nmi);
      if (live) begin
        if (im_set) int_mode <= im_val;
        in_service <= (in_service & ~clr_vec) | set_vec;
        if (take_nmi) begin
          IFF2 <= IFF1;
          IFF1 <= 1'b0;
        end else if (take_irq || di) begin
          IFF1 <= 1'b0;
          IFF2 <= 1'b0;
        end else if (ei) begin
          IFF1 <= 1'b1;
          IFF2 <= 1'b1;
        end else if (retn) begin
          IFF1 <= IFF2;
        end
        if (di)                          shadow <= 2'd0;
        else if (ei)                     shadow <= 2'(EI_DELAY);
        else if (retire && shadow != 2'd0) shadow <= shadow - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl_nested.sv
// Scoreboard bench for int_ctrl_nested: directed steps queue expectations, a negedge monitor checks them.
module tb_int_ctrl_nested;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  irq_in, irq_mask;
  logic        nmi_in, ei, di, reti, retn, im_set, retire, stall, int_ack;
  logic [1:0]  im_val;
  logic [7:0]  i_reg;
  logic        interrupt_RQ, is_nmi, IFF1, IFF2;
  logic [15:0] target_pc;
  logic [1:0]  int_mode;
  logic [3:0]  in_service;

  typedef struct packed {
    logic        rq;
    logic        chk_pc;
    logic [15:0] pc;
    logic        nmi;
    logic        iff1;
    logic        iff2;
    logic [3:0]  isv;
    logic [1:0]  mode;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  always #5 CLK = ~CLK;

  int_ctrl_nested #(.NUM_IRQ(4), .EI_DELAY(1)) dut (
    .CLK(CLK), .RST(RST), .irq_in(irq_in), .irq_mask(irq_mask), .nmi_in(nmi_in),
    .ei(ei), .di(di), .reti(reti), .retn(retn), .im_set(im_set), .im_val(im_val),
    .i_reg(i_reg), .retire(retire), .stall(stall), .int_ack(int_ack),
    .interrupt_RQ(interrupt_RQ), .target_pc(target_pc), .is_nmi(is_nmi),
    .IFF1(IFF1), .IFF2(IFF2), .int_mode(int_mode), .in_service(in_service)
  );

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      logic  ok;
      e  = exp_q.pop_front();
      n  = name_q.pop_front();
      ok = (interrupt_RQ == e.rq) && (is_nmi == e.nmi) && (IFF1 == e.iff1) &&
           (IFF2 == e.iff2) && (in_service == e.isv) && (int_mode == e.mode) &&
           (!e.chk_pc || target_pc == e.pc);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s: got rq=%b pc=%h nmi=%b iff=%b%b isv=%b mode=%0d, want rq=%b pc=%h nmi=%b iff=%b%b isv=%b mode=%0d",
                 n, interrupt_RQ, target_pc, is_nmi, IFF1, IFF2, in_service, int_mode,
                 e.rq, e.pc, e.nmi, e.iff1, e.iff2, e.isv, e.mode);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
    ei = 0; di = 0; reti = 0; retn = 0; im_set = 0; retire = 0; int_ack = 0;
  endtask

  task automatic expect_state(input string nm, input logic rq, input logic [15:0] pc,
                              input logic nmi, input logic i1, input logic i2,
                              input logic [3:0] isv, input logic [1:0] mode);
    exp_t e;
    e = '{rq: rq, chk_pc: 1'b1, pc: pc, nmi: nmi, iff1: i1, iff2: i2, isv: isv, mode: mode};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: monitor did not consume expectation, queue=%0d want 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    RST = 1; irq_in = 0; irq_mask = 0; nmi_in = 0; ei = 0; di = 0; reti = 0; retn = 0;
    im_set = 0; im_val = 0; i_reg = 0; retire = 0; stall = 0; int_ack = 0;
    cyc(); cyc();
    RST = 0;
    expect_state("reset", 0, 16'h0038, 0, 0, 0, 4'b0000, 2'd0);

    // IM2 vectoring after EI shadow expires
    im_set = 1; im_val = 2; i_reg = 8'h3F; ei = 1; cyc();
    irq_in = 4'b0100;
    expect_state("ei_shadow", 0, 16'h3F04, 0, 1, 1, 4'b0000, 2'd2);
    retire = 1; cyc();
    expect_state("im2_req", 1, 16'h3F04, 0, 1, 1, 4'b0000, 2'd2);
    int_ack = 1; cyc();
    expect_state("im2_ack", 0, 16'h3F00, 0, 0, 0, 4'b0100, 2'd2);

    // Nesting: higher-priority channel 1 preempts, channel 3 stays blocked
    irq_in = 4'b1010; ei = 1; retire = 1; cyc();
    expect_state("nest_shadow", 0, 16'h3F02, 0, 1, 1, 4'b0100, 2'd2);
    retire = 1; cyc();
    expect_state("nest_req", 1, 16'h3F02, 0, 1, 1, 4'b0100, 2'd2);
    int_ack = 1; cyc();
    expect_state("nest_ack", 0, 16'h3F00, 0, 0, 0, 4'b0110, 2'd2);
    reti = 1; cyc();
    expect_state("reti", 0, 16'h3F02, 0, 0, 0, 4'b0100, 2'd2);
    reti = 1; cyc();
    expect_state("reti2", 0, 16'h3F02, 0, 0, 0, 4'b0000, 2'd2);
    irq_in = 4'b0000; reti = 1; cyc();
    expect_state("reti_empty", 0, 16'h3F00, 0, 0, 0, 4'b0000, 2'd2);

    // EI shadow and DI interaction
    ei = 1; cyc();
    irq_in = 4'b0001;
    expect_state("shadow_block", 0, 16'h3F00, 0, 1, 1, 4'b0000, 2'd2);
    retire = 1; cyc();
    expect_state("shadow_release", 1, 16'h3F00, 0, 1, 1, 4'b0000, 2'd2);
    di = 1; cyc();
    expect_state("di", 0, 16'h3F00, 0, 0, 0, 4'b0000, 2'd2);
    ei = 1; cyc();
    di = 1; cyc();
    retire = 1; cyc();
    expect_state("di_before_retire", 0, 16'h3F00, 0, 0, 0, 4'b0000, 2'd2);
    int_ack = 1; cyc();
    expect_state("ack_no_rq", 0, 16'h3F00, 0, 0, 0, 4'b0000, 2'd2);

    // NMI edge, acceptance copies IFF1 into IFF2, RETN restores
    irq_in = 4'b0000; ei = 1; cyc();
    retire = 1; cyc();
    nmi_in = 1; cyc();
    nmi_in = 0;
    expect_state("nmi_req", 1, 16'h0066, 1, 1, 1, 4'b0000, 2'd2);
    int_ack = 1; cyc();
    expect_state("nmi_ack", 0, 16'h3F00, 0, 0, 1, 4'b0000, 2'd2);
    retn = 1; cyc();
    expect_state("retn", 0, 16'h3F00, 0, 1, 1, 4'b0000, 2'd2);

    // Stall freezes state while NMI edge capture continues
    di = 1; cyc();
    irq_in = 4'b0001; stall = 1; ei = 1; int_ack = 1;
    for (int k = 0; k < 5; k++) begin
      nmi_in = (k == 2);
      @(posedge CLK);
      #1;
    end
    nmi_in = 0;
    expect_state("stall_hold", 1, 16'h0066, 1, 0, 0, 4'b0000, 2'd2);
    stall = 0; ei = 0; int_ack = 1; cyc();
    expect_state("stall_nmi_taken", 0, 16'h3F00, 0, 0, 0, 4'b0000, 2'd2);

    // IM1 fixed vector and masking
    im_set = 1; im_val = 1; ei = 1; cyc();
    retire = 1; cyc();
    expect_state("im1_vec", 1, 16'h0038, 0, 1, 1, 4'b0000, 2'd1);
    irq_mask = 4'b0011; irq_in = 4'b0011; cyc();
    expect_state("masked", 0, 16'h0038, 0, 1, 1, 4'b0000, 2'd1);
    irq_mask = 4'b0000; irq_in = 4'b0000;

`ifdef INT_EDGE_EN
    // A short pulse while disabled is remembered in the pending latch
    di = 1; im_set = 1; im_val = 2; cyc();
    irq_in = 4'b0100; cyc();
    irq_in = 4'b0000; cyc();
    expect_state("edge_pending", 0, 16'h3F04, 0, 0, 0, 4'b0000, 2'd2);
    ei = 1; cyc();
    retire = 1; cyc();
    expect_state("edge_req", 1, 16'h3F04, 0, 1, 1, 4'b0000, 2'd2);
    int_ack = 1; cyc();
    expect_state("edge_ack", 0, 16'h3F00, 0, 0, 0, 4'b0100, 2'd2);
`endif

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
